// File: rtl/adder_pkg.sv
// Shared constants for the adder leaf cells.
package adder_pkg;

  // Default operand width of ripple_carry_adder.
  localparam int unsigned RCA_DEFAULT_WIDTH = 4;

endpackage : adder_pkg

// File: rtl/full_adder.sv
// 1-bit full adder, purely combinational.
//   a, b  : operand bits
//   cin   : carry into this bit
//   sum   : a ^ b ^ cin
//   cout  : carry out of this bit
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  // Propagate term is shared between the sum and the carry.
  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/ripple_carry_adder.sv
// Registered WIDTH-bit ripple-carry adder: {cout,sum} <= a + b + cin, one cycle latency.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears sum and cout
//   a, b   : unsigned operands
//   cin    : carry into bit 0
//   sum    : registered (a + b + cin) mod 2^WIDTH
//   cout   : registered carry out of bit WIDTH-1
module ripple_carry_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  // Carry chain: bit i consumes c[i] and produces c[i+1].
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (s[i]),
      .cout (c[i+1])
    );
  end

  // Output register; reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= s;
      cout <= c[WIDTH];
    end
  end

endmodule : ripple_carry_adder

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder (WIDTH=4 and WIDTH=8 instances).
module tb_ripple_carry_adder;

  logic       clk;
  logic       rst_n;
  logic [3:0] a, b, sum;
  logic       cin, cout;
  logic [7:0] a8, b8, sum8;
  logic       cin8, cout8;

  int checks;
  int failures;

  logic [4:0] exp_q[$];
  logic [8:0] exp8_q[$];

  ripple_carry_adder #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout)
  );

  ripple_carry_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .sum(sum8), .cout(cout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one 4-bit vector and queue its expected {cout,sum}.
  task automatic drive4(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                        input logic [4:0] e);
    a = va; b = vb; cin = vc;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [4:0] e;
    rst_n = 1'b0;
    a = 4'd9; b = 4'd9; cin = 1'b1;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    #2;
    checks++;
    if ({cout, sum} !== 5'd0) begin
      failures++;
      $display("FAIL reset_async: got cout=%b sum=%0d expected cout=0 sum=0", cout, sum);
    end
    checks++;
    if ({cout8, sum8} !== 9'd0) begin
      failures++;
      $display("FAIL reset_async8: got cout=%b sum=%0d expected cout=0 sum=0", cout8, sum8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({1'b1, 4'd3});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({cout, sum} !== e) begin
      failures++;
      $display("FAIL reset_release: got %0d expected %0d", {cout, sum}, e);
    end
  endtask

  task automatic test_simple();
    logic [4:0] e;
    drive4(4'd3, 4'd5, 1'b0, {1'b0, 4'd8});
    @(negedge clk);
    drive4(4'd3, 4'd5, 1'b1, {1'b0, 4'd9});
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      checks++;
      if ({cout, sum} !== e) begin
        failures++;
        $display("FAIL simple_add[%0d]: got %0d expected %0d", k, {cout, sum}, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] e;
    drive4(4'd15, 4'd1, 1'b0, {1'b1, 4'd0});
    @(negedge clk);
    drive4(4'd15, 4'd15, 1'b1, {1'b1, 4'd15});
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      checks++;
      if ({cout, sum} !== e) begin
        failures++;
        $display("FAIL wrap[%0d]: got %0d expected %0d", k, {cout, sum}, e);
      end
      @(negedge clk);
    end
    // Hold operands: output must not move.
    e = {1'b1, 4'd15};
    checks++;
    if ({cout, sum} !== e) begin
      failures++;
      $display("FAIL hold: got %0d expected %0d", {cout, sum}, e);
    end
  endtask

  task automatic test_exhaustive();
    logic [4:0] e;
    int         miss;
    miss = 0;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          drive4(4'(ia), 4'(ib), 1'(ic), 5'(ia + ib + ic));
          @(negedge clk);
          e = exp_q.pop_front();
          checks++;
          if ({cout, sum} !== e) begin
            failures++;
            miss++;
            if (miss <= 10)
              $display("FAIL exhaustive a=%0d b=%0d cin=%0d: got %0d expected %0d",
                       ia, ib, ic, {cout, sum}, e);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [3:0] va, vb;
    logic       vc;
    logic [4:0] e;
    for (int k = 0; k < 3; k++) begin
      va = 4'($urandom_range(15));
      vb = 4'($urandom_range(15));
      vc = 1'($urandom_range(1));
      drive4(va, vb, vc, 5'(va) + 5'(vb) + 5'(vc));
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({cout, sum} !== 5'd0) begin
        failures++;
        $display("FAIL midreset_clear[%0d]: got %0d expected 0", k, {cout, sum});
      end
      #1;
      rst_n = 1'b1;
      // The result captured before the pulse is gone; the next edge recomputes it.
      exp_q.delete();
      exp_q.push_back(5'(va) + 5'(vb) + 5'(vc));
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({cout, sum} !== e) begin
        failures++;
        $display("FAIL midreset_release[%0d]: got %0d expected %0d", k, {cout, sum}, e);
      end
    end
  endtask

  task automatic test_width8();
    logic [8:0] e;
    a8 = 8'd255; b8 = 8'd1; cin8 = 1'b0;
    exp8_q.push_back({1'b1, 8'd0});
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd100; cin8 = 1'b1;
    exp8_q.push_back({1'b1, 8'd45});
    for (int k = 0; k < 2; k++) begin
      e = exp8_q.pop_front();
      checks++;
      if ({cout8, sum8} !== e) begin
        failures++;
        $display("FAIL width8[%0d]: got %0d expected %0d", k, {cout8, sum8}, e);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_simple();
    test_wrap();
    test_exhaustive();
    test_reset_midstream();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ripple_carry_adder
